// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (opcode[2:0])
//   - bit positions inside the 4-bit flags word {N, V, C, Z}
//   - FSM state type
package alu_pkg;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one multiplier bit
// per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin (must only be pulsed while !busy)
//   a, b       : multiplicand / multiplier (WIDTH bits)
//   busy       : an operation is in progress
//   done       : this cycle performs the final iteration; product is valid now
//   product    : 2*WIDTH result, meaningful while done=1
//
// The product is presented combinationally during the last iteration so the
// parent can register it on the same edge that retires the operation,
// giving exactly WIDTH edges between the load edge and the result edge.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done     = busy_q && (count_q == CW'(WIDTH - 1));
  assign busy     = busy_q;
  assign product  = acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an optional
// iterative multiplier.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (opcode, a, b)
//   opcode               : only [2:0] decoded
//   a, b                 : operands, captured on accept
//   out_valid / out_ready: result handshake (res, flags)
//   res                  : WIDTH-bit result
//   flags                : {N, V, C, Z}
//
// state   | meaning
// --------+----------------------------------------------------
// ST_IDLE | ready for a new op (subject to output backpressure)
// ST_MUL  | multiplier iterating; input side stalled
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         op;
  logic               accept;
  logic               consume;
  logic               is_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               wb_en;
  logic [WIDTH-1:0]   wb_res;
  logic [3:0]         wb_flags;
  logic               unused_opcode_hi;

  assign op               = opcode[2:0];
  assign unused_opcode_hi = ^opcode[7:3];

  // Output slot is free if empty or being drained this same edge.
  assign in_ready  = (state_q == ST_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign is_mul    = (op == OP_MUL) && (ENABLE_MUL != 0);
  assign mul_start = accept && is_mul;

  generate
    if (ENABLE_MUL != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_OR:   alu_res = a | b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_AND:  alu_res = a & b;
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow.
        {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_RSV:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wb_en    = (accept && !is_mul) || mul_done;
    wb_res   = mul_done ? mul_prod[WIDTH-1:0] : alu_res;
    wb_flags = '0;
    wb_flags[FLG_Z] = (wb_res == '0);
    wb_flags[FLG_N] = wb_res[WIDTH-1];
    wb_flags[FLG_C] = mul_done ? (|mul_prod[2*WIDTH-1:WIDTH]) : alu_c;
    wb_flags[FLG_V] = mul_done ? 1'b0 : alu_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      flags     <= '0;
    end else if (wb_en) begin
      out_valid <= 1'b1;
      res       <= wb_res;
      flags     <= wb_flags;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed corner cases plus randomized traffic for alu_seq,
// checked every cycle against a transaction-level model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   opcode, a, b, res;
  logic [3:0]   flags;

  logic         d0_in_valid, d0_in_ready, d0_out_valid;
  logic [7:0]   d0_opcode, d0_a, d0_b, d0_res;
  logic [3:0]   d0_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq #(.WIDTH(W), .ENABLE_MUL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .flags(flags)
  );

  alu_seq #(.WIDTH(W), .ENABLE_MUL(0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .opcode(d0_opcode), .a(d0_a), .b(d0_b), .out_valid(d0_out_valid),
    .out_ready(1'b1), .res(d0_res), .flags(d0_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics: returns {N, V, C, Z, res[7:0]}.
  function automatic logic [11:0] ref_op(input logic [7:0] opc, input logic [7:0] x,
                                         input logic [7:0] y, input bit mul_en);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int full;
    bit c = 0;
    bit v = 0;
    logic [7:0] r = 8'h00;
    case (opc[2:0])
      3'd0: r = x | y;
      3'd1: r = ~(x & y);
      3'd2: r = ~(x | y);
      3'd3: r = x & y;
      3'd4: begin
        full = ux + uy;
        r = 8'(full);
        c = (full > 255);
        v = ((sx + sy) > 127) || ((sx + sy) < -128);
      end
      3'd5: begin
        full = ux - uy;
        r = 8'(full);
        c = (ux < uy);
        v = ((sx - sy) > 127) || ((sx - sy) < -128);
      end
      3'd6: begin
        if (mul_en) begin
          full = ux * uy;
          r = 8'(full);
          c = (full > 255);
        end
      end
      default: r = 8'h00;
    endcase
    return {r[7], v, c, (r == 8'h00), r};
  endfunction

  // Transaction-level model: one output slot plus an optional pending
  // multiply that matures W edges after it was accepted.
  bit          m_ov    = 0;
  logic [7:0]  m_res   = 0;
  logic [3:0]  m_flags = 0;
  bit          m_pend  = 0;
  int          m_cnt   = 0;
  logic [11:0] m_pv    = 0;

  always @(posedge clk or negedge rst_n) begin
    bit e_rdy;
    logic [11:0] pv;
    if (!rst_n) begin
      m_ov = 0; m_res = 0; m_flags = 0; m_pend = 0; m_cnt = 0;
    end else begin
      e_rdy = !m_pend && (!m_ov || out_ready);
      if (m_ov && out_ready) m_ov = 0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_pend = 0;
          m_ov = 1;
          {m_flags, m_res} = m_pv;
        end
      end
      if (in_valid && e_rdy) begin
        pv = ref_op(opcode, a, b, 1'b1);
        if (opcode[2:0] == 3'b110) begin
          m_pend = 1;
          m_cnt = W;
          m_pv = pv;
        end else begin
          m_ov = 1;
          {m_flags, m_res} = pv;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, m_ov);
    if (rst_n) check("in_ready", in_ready, !m_pend && (!m_ov || out_ready));
    if (m_ov) begin
      check("res", res, m_res);
      check("flags", flags, m_flags);
    end
  end

  task automatic issue(input logic [7:0] opc, input logic [7:0] x, input logic [7:0] y);
    bit got = 0;
    in_valid = 1; opcode = opc; a = x; b = y;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready never 1 for opcode %0h", opc);
    end
    in_valid = 0;
    opcode = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  // Waits for out_valid; exp_wait counts negedges after the accept edge.
  task automatic wait_result(input string name, input logic [7:0] er, input logic [3:0] ef,
                             input int exp_wait);
    bit seen = 0;
    int n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        n = i;
      end
    end
    check({name, "_latency"}, n, exp_wait);
    check({name, "_res"}, res, er);
    check({name, "_flags"}, flags, ef);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    bit was_acc;
    in_valid = 0; opcode = 0; a = 0; b = 0; out_ready = 1;
    d0_in_valid = 0; d0_opcode = 0; d0_a = 0; d0_b = 0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_flags", flags, 0);
    check("rst_d0_out_valid", d0_out_valid, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Arithmetic corners
    issue(8'h04, 8'hF0, 8'h20); wait_result("add_carry", 8'h10, 4'b0010, 1);
    issue(8'h05, 8'h80, 8'h01); wait_result("sub_ovf",   8'h7F, 4'b0100, 1);
    issue(8'h05, 8'h05, 8'h05); wait_result("sub_zero",  8'h00, 4'b0001, 1);
    issue(8'h05, 8'h03, 8'h05); wait_result("sub_borrow",8'hFE, 4'b1010, 1);
    issue(8'h01, 8'hFF, 8'hFF); wait_result("nand_zero", 8'h00, 4'b0001, 1);
    issue(8'h0F, 8'h12, 8'h34); wait_result("rsv_hi",    8'h00, 4'b0001, 1);

    // Multiply
    issue(8'h06, 8'h0F, 8'h11); wait_result("mul_ff",  8'hFF, 4'b1000, W + 1);
    issue(8'h06, 8'h10, 8'h10); wait_result("mul_ovf", 8'h00, 4'b0011, W + 1);

    // Backpressure then streaming
    out_ready = 0;
    issue(8'h00, 8'h0A, 8'h50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_res", res, 8'h5A);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    c0 = cyc;
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] lo, hi;
      lo = 8'(i);
      hi = 8'(i << 4);
      issue(8'h00, lo, hi);
      check("stream_res", res, lo | hi);
      check("stream_valid", out_valid, 1);
    end
    check("stream_cycles", cyc - c0, 4);
    @(posedge clk);
    #1;

    // Reset during a multiply
    issue(8'h06, 8'h0F, 8'h0F);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_res", res, 0);
    check("abort_flags", flags, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    issue(8'h04, 8'h01, 8'h01); wait_result("post_abort_add", 8'h02, 4'b0000, 1);

    // Build without multiplier
    d0_in_valid = 1; d0_opcode = 8'h06; d0_a = 8'h03; d0_b = 8'h04;
    @(negedge clk);
    check("nomul_in_ready", d0_in_ready, 1);
    @(posedge clk);
    #1;
    d0_in_valid = 1; d0_opcode = 8'h04; d0_a = 8'h7F; d0_b = 8'h01;
    @(negedge clk);
    check("nomul_mul_valid", d0_out_valid, 1);
    check("nomul_mul_res", d0_res, 8'h00);
    check("nomul_mul_flags", d0_flags, 4'b0001);
    @(posedge clk);
    #1;
    d0_in_valid = 0;
    @(negedge clk);
    check("nomul_add_res", d0_res, 8'h80);
    check("nomul_add_flags", d0_flags, 4'b1100);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      was_acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || was_acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        opcode = 8'($urandom);
        a = pick();
        b = pick();
      end
    end
    in_valid = 0;
    out_ready = 1;
    repeat (20) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's combinational 8-bit ALU. It keeps the opcode[2:0] encoding for OR/NAND/NOR/AND/ADD/SUB. It adds:
- a multi-cycle iterative multiply;
- registered status flags;
- valid/ready flow control on both input and output.

It sits between the decode stage and the register-file writeback. At most one operation is in flight.

Parameters:
WIDTH, 8, operand and result width in bits (>=2).
ENABLE_MUL, 1, 1 = opcode 3'b110 performs iterative multiply; 0 = treated as reserved.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
in_valid  input  1  opcode/a/b valid.
in_ready  output  1  block can accept an operation this cycle.
opcode  input  8  operation select; only opcode[2:0] decoded, bits [7:3] ignored.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  res/flags valid.
out_ready  input  1  consumer accepts res/flags.
res  output  WIDTH  result.
flags  output  4  {N, V, C, Z} = flags[3:0].

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, res=0, flags=0, FSM=IDLE, multiply counters cleared. in_ready=1 once rst_n is high.
- Handshakes:
  - Input is accepted on a rising edge when in_valid && in_ready.
  - Output is consumed on a rising edge when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, res and flags hold stable.
  - out_valid never drops without a consume.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A consume and a new accept in the same cycle are legal, giving 1 op/cycle throughput for single-cycle ops.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on accept of 110 when ENABLE_MUL=1.
  - MUL -> IDLE when the final iteration writes the output.
  - All other opcodes stay in IDLE.
- Latency:
  - Opcodes 000–101, 111, and 110 with ENABLE_MUL=0: out_valid=1 after the edge following the accept edge (1 cycle).
  - MUL: the accept edge loads multiplicand, multiplier and a 2*WIDTH accumulator, with count=0. Each following edge processes one multiplier bit (shift-add). out_valid=1 after accept edge + WIDTH edges. in_ready=0 throughout.
- Operations (results truncated to WIDTH bits):
  - 000: a|b.
  - 001: ~(a&b).
  - 010: ~(a|b).
  - 011: a&b.
  - 100: a+b.
  - 101: a-b.
  - 110: low WIDTH bits of unsigned a*b.
  - 111 (and 110 when ENABLE_MUL=0): res=0.
- Flags:
  - Z = (res==0) for every op.
  - N = res[WIDTH-1] for every op.
  - C:
    - ADD: carry-out of the WIDTH-bit sum.
    - SUB: borrow (1 when a<b unsigned).
    - MUL: 1 if the upper WIDTH product bits are nonzero.
    - Otherwise 0.
  - V:
    - ADD/SUB: two's-complement signed overflow.
    - Otherwise 0.
- Operands are captured at accept. Input changes after acceptance have no effect.
- Reset asserted mid-MUL aborts the operation; no result is produced.
- in_valid with in_ready=0 is ignored. The producer must hold it.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_OR=3'b000, OP_NAND, OP_NOR, OP_AND, OP_ADD, OP_SUB, OP_MUL=3'b110, OP_RSV=3'b111;
  - flag index constants FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3;
  - FSM state typedef.
- One sub-module, alu_mul_iter:
  - the WIDTH-cycle shift-add multiplier, with start/busy/done and a 2*WIDTH product;
  - instantiated only when ENABLE_MUL=1.

Test Plan:
1. ADD a=0xF0, b=0x20, out_ready=1 → res=0x10, flags C=1 V=0 Z=0 N=0, out_valid one cycle after accept. SUB a=0x80, b=0x01 → res=0x7F, V=1, C=0, N=0.
2. SUB 0x05-0x05 → res=0x00, Z=1, C=0. SUB 0x03-0x05 → res=0xFE, C=1, N=1. NAND 0xFF,0xFF → 0x00, Z=1. opcode=0x0F (low bits 111) → res=0x00, Z=1.
3. MUL 0x0F*0x11 → res=0xFF, C=0, N=1, out_valid exactly 8 cycles after accept, in_ready=0 for those cycles. MUL 0x10*0x10 → res=0x00, C=1, Z=1.
4. Backpressure: issue OR 0x0A|0x50, hold out_ready=0 for 3 cycles → res=0x5A stable, in_ready=0. Then stream 4 back-to-back ORs with out_ready=1 → one result per cycle, in order.
5. Reset mid-MUL: pull rst_n low 4 cycles after a MUL accept → out_valid=0, res=0, flags=0 immediately. After release, in_ready=1, and a subsequent ADD 0x01+0x01 returns 0x02.
6. ENABLE_MUL=0 build: opcode 110 with a=0x03, b=0x04 → res=0x00, Z=1, 1-cycle latency.
